// File: rtl/hall_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hall_pkg : shared Hall code mapping, fault indices and direction values   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package hall_pkg;

  localparam logic [2:0] c_CODE_INV_LO = 3'b000;
  localparam logic [2:0] c_CODE_INV_HI = 3'b111;

  localparam int FLT_INVALID = 0;
  localparam int FLT_JUMP    = 1;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic [2:0] {
    TR_NONE    = 3'd0,
    TR_INVALID = 3'd1,
    TR_RESYNC  = 3'd2,
    TR_CW      = 3'd3,
    TR_CCW     = 3'd4,
    TR_JUMP    = 3'd5
  } trans_e;

  function automatic logic code_is_valid(input logic [2:0] code);
    return (code != c_CODE_INV_LO) && (code != c_CODE_INV_HI);
  endfunction

  function automatic logic [2:0] hall_sector(input logic [2:0] code);
    logic [2:0] s;
    s = 3'd0;
    case (code)
      3'b001:  s = 3'd0;
      3'b011:  s = 3'd1;
      3'b010:  s = 3'd2;
      3'b110:  s = 3'd3;
      3'b100:  s = 3'd4;
      3'b101:  s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] sector_next(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sector_prev(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hall_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hall_debounce : 3-bit vector glitch filter with a stability counter       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hall_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  localparam logic [7:0] c_THRESH = 8'(DEBOUNCE_CYCLES);

  logic [2:0] cand_q;
  logic [2:0] q_q;
  logic [7:0] run_q;
  logic [7:0] run_d;

  // run_d counts consecutive samples of d_i including the current one
  always_comb begin
    run_d = 8'd1;
    if (d_i == cand_q) begin
      run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= 3'b000;
      run_q  <= 8'd0;
      q_q    <= 3'b000;
    end else begin
      cand_q <= d_i;
      run_q  <= run_d;
      if (run_d >= c_THRESH) begin
        q_q <= d_i;
      end
    end
  end

  assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/hall_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hall_decoder : Hall sensor to sector/direction/period/fault decoder.      |
// | Define HALL_DEBOUNCE_EN to insert the glitch filter.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module hall_decoder
  import hall_pkg::*;
#(
  parameter int PERIOD_W        = 20,
  parameter int STALL_CYCLES    = 1000000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          HS,
  input  logic                fault_clr,
  output logic [2:0]          sector,
  output logic                sector_valid,
  output logic                dir,
  output logic                edge_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic [1:0]          fault
);

  localparam logic [PERIOD_W-1:0] c_STALL = PERIOD_W'(STALL_CYCLES);

  logic [2:0]          sync1_q;
  logic [2:0]          sync2_q;
  logic [2:0]          hf;
  logic [2:0]          code_q;
  logic [2:0]          sector_q;
  logic [2:0]          new_sector;
  logic                sector_valid_q;
  logic                dir_q;
  logic                dir_new;
  logic                edge_pulse_q;
  logic                period_valid_q;
  logic                stalled_q;
  logic                have_edge_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [1:0]          fault_q;
  logic [1:0]          fault_d;
  trans_e              trans;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= HS;
      sync2_q <= sync1_q;
    end
  end

`ifdef HALL_DEBOUNCE_EN
  hall_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .d_i (sync2_q),
    .q_o (hf)
  );
`else
  logic [7:0] unused_debounce;
  assign unused_debounce = 8'(DEBOUNCE_CYCLES);
  assign hf = sync2_q;
`endif

  assign new_sector = hall_sector(hf);
  assign cnt_inc    = (cnt_q == {PERIOD_W{1'b1}}) ? cnt_q : cnt_q + PERIOD_W'(1);

  // Classify the change of the filtered code against the last decoded one
  always_comb begin
    trans = TR_NONE;
    if (hf != code_q) begin
      if (!code_is_valid(hf)) begin
        trans = TR_INVALID;
      end else if (!sector_valid_q) begin
        trans = TR_RESYNC;
      end else if (new_sector == sector_next(sector_q)) begin
        trans = TR_CW;
      end else if (new_sector == sector_prev(sector_q)) begin
        trans = TR_CCW;
      end else begin
        trans = TR_JUMP;
      end
    end
  end

  assign dir_new = (trans == TR_CW) ? DIR_CW : DIR_CCW;

  // A clear and a fresh fault in the same cycle leaves the fresh fault set
  always_comb begin
    fault_d = fault_clr ? 2'b00 : fault_q;
    if (trans == TR_INVALID) fault_d[FLT_INVALID] = 1'b1;
    if (trans == TR_JUMP)    fault_d[FLT_JUMP]    = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q         <= 3'b000;
      sector_q       <= 3'd0;
      sector_valid_q <= 1'b0;
      dir_q          <= 1'b0;
      edge_pulse_q   <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      have_edge_q    <= 1'b0;
      cnt_q          <= '0;
      fault_q        <= 2'b00;
    end else begin
      code_q       <= hf;
      edge_pulse_q <= 1'b0;
      cnt_q        <= cnt_inc;
      fault_q      <= fault_d;
      if (cnt_inc == c_STALL) begin
        stalled_q      <= 1'b1;
        period_valid_q <= 1'b0;
      end
      // Edge handling below overrides a stall that expires in the same cycle
      case (trans)
        TR_INVALID: begin
          sector_valid_q <= 1'b0;
        end
        TR_RESYNC: begin
          sector_q       <= new_sector;
          sector_valid_q <= 1'b1;
        end
        TR_CW, TR_CCW: begin
          sector_q       <= new_sector;
          dir_q          <= dir_new;
          edge_pulse_q   <= 1'b1;
          period_q       <= cnt_inc;
          cnt_q          <= '0;
          period_valid_q <= have_edge_q && (dir_new == dir_q) && !stalled_q;
          stalled_q      <= 1'b0;
          have_edge_q    <= 1'b1;
        end
        TR_JUMP: begin
          sector_q       <= new_sector;
          period_valid_q <= 1'b0;
          cnt_q          <= '0;
          have_edge_q    <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign sector       = sector_q;
  assign sector_valid = sector_valid_q;
  assign dir          = dir_q;
  assign edge_pulse   = edge_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;
  assign fault        = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_hall_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hall_decoder : directed scoreboard bench for hall_decoder             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_hall_decoder;

  localparam int PW    = 20;
  localparam int STALL = 500;
`ifdef HALL_DEBOUNCE_EN
  localparam int LAT          = 18;
  localparam int GLITCH_EXTRA = 110;
`else
  localparam int LAT          = 2;
  localparam int GLITCH_EXTRA = 0;
`endif

  logic          clk;
  logic          rst;
  logic [2:0]    HS;
  logic          fault_clr;
  logic [2:0]    sector;
  logic          sector_valid;
  logic          dir;
  logic          edge_pulse;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stalled;
  logic [1:0]    fault;

  hall_decoder #(
    .PERIOD_W        (PW),
    .STALL_CYCLES    (STALL),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .HS           (HS),
    .fault_clr    (fault_clr),
    .sector       (sector),
    .sector_valid (sector_valid),
    .dir          (dir),
    .edge_pulse   (edge_pulse),
    .period       (period),
    .period_valid (period_valid),
    .stalled      (stalled),
    .fault        (fault)
  );

  typedef struct packed {
    logic [2:0]    sec;
    logic          d;
    logic [PW-1:0] per;
    logic          pv;
    logic          chk_per;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_edge_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_edge(input int sec, input bit d, input int per, input bit pv, input bit chk);
    exp_t e;
    e.sec     = 3'(sec);
    e.d       = d;
    e.per     = PW'(per);
    e.pv      = pv;
    e.chk_per = chk;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [2:0] code, input int n);
    HS = code;
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input logic [2:0] code, input int sec, input bit d, input int per, input bit pv);
    expect_edge(sec, d, per, pv, 1'b1);
    hold(code, 100);
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  // Monitor: pops an expectation for every edge_pulse and times stall onset
  initial begin
    logic stalled_prev;
    exp_t e;
    stalled_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (edge_pulse) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_edge: got edge_pulse with sector %0d at cycle %0d, required none",
                   sector, cyc);
        end else begin
          e = exp_q.pop_front();
          check("edge_sector", int'(sector), int'(e.sec));
          check("edge_dir", int'(dir), int'(e.d));
          check("edge_period_valid", int'(period_valid), int'(e.pv));
          if (e.chk_per) check("edge_period", int'(period), int'(e.per));
        end
        last_edge_cyc = cyc;
      end
      if (stalled && !stalled_prev) check("stall_delay", cyc - last_edge_cyc, STALL);
      stalled_prev = stalled;
    end
  end

  initial begin
    int c0;
    rst       = 1'b1;
    HS        = 3'b000;
    fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sector", int'(sector), 0);
    check("reset_sector_valid", int'(sector_valid), 0);
    check("reset_dir", int'(dir), 0);
    check("reset_edge_pulse", int'(edge_pulse), 0);
    check("reset_period", int'(period), 0);
    check("reset_period_valid", int'(period_valid), 0);
    check("reset_stalled", int'(stalled), 0);
    check("reset_fault", int'(fault), 0);
    rst = 1'b0;

    // First legal code only resynchronises
    hold(3'b001, 100);
    check("resync_sector", int'(sector), 0);
    check("resync_valid", int'(sector_valid), 1);
    check("resync_dir", int'(dir), 0);

    // Forward rotation
    expect_edge(1, 1'b1, 0, 1'b0, 1'b0);
    c0 = cyc;
    hold(3'b011, 100);
    check("edge_latency", last_edge_cyc - (c0 + 1), LAT);
    step(3'b010, 2, 1'b1, 100, 1'b1);
    step(3'b110, 3, 1'b1, 100, 1'b1);
    step(3'b100, 4, 1'b1, 100, 1'b1);
    step(3'b101, 5, 1'b1, 100, 1'b1);
    step(3'b001, 0, 1'b1, 100, 1'b1);
    step(3'b011, 1, 1'b1, 100, 1'b1);

    // Reverse rotation: first reversed edge has no valid period
    step(3'b001, 0, 1'b0, 100, 1'b0);
    step(3'b101, 5, 1'b0, 100, 1'b1);
    step(3'b100, 4, 1'b0, 100, 1'b1);
    step(3'b110, 3, 1'b0, 100, 1'b1);
    step(3'b010, 2, 1'b0, 100, 1'b1);
    step(3'b011, 1, 1'b0, 100, 1'b1);

    // Invalid code, resync without edge, then clear
    hold(3'b111, 50);
    check("invalid_fault", int'(fault), 1);
    check("invalid_sector_valid", int'(sector_valid), 0);
    check("invalid_sector_hold", int'(sector), 1);
    hold(3'b011, 60);
    check("after_invalid_sector", int'(sector), 1);
    check("after_invalid_valid", int'(sector_valid), 1);
    check("after_invalid_fault", int'(fault), 1);
    pulse_clr();
    hold(3'b011, 39);
    check("fault_clr_invalid", int'(fault), 0);
    step(3'b001, 0, 1'b0, 250, 1'b1);

    // Illegal jump 001 -> 110
    hold(3'b110, 60);
    check("jump_fault", int'(fault), 2);
    check("jump_sector", int'(sector), 3);
    check("jump_period_valid", int'(period_valid), 0);
    check("jump_sector_valid", int'(sector_valid), 1);
    pulse_clr();
    hold(3'b110, 39);
    check("fault_clr_jump", int'(fault), 0);

    // Stall, then recovery
    expect_edge(4, 1'b1, 100, 1'b0, 1'b1);
    hold(3'b100, 600);
    check("stall_flag", int'(stalled), 1);
    check("stall_period_valid", int'(period_valid), 0);
    expect_edge(5, 1'b1, 600, 1'b0, 1'b1);
    hold(3'b101, 100);
    check("stall_cleared", int'(stalled), 0);
    step(3'b001, 0, 1'b1, 100, 1'b1);

`ifdef HALL_DEBOUNCE_EN
    hold(3'b011, 10);
    hold(3'b001, 100);
    check("glitch_fault", int'(fault), 0);
    check("glitch_sector", int'(sector), 0);
`endif
    expect_edge(1, 1'b1, 100 + GLITCH_EXTRA, 1'b1, 1'b1);
    c0 = cyc;
    hold(3'b011, 100);
    check("final_latency", last_edge_cyc - (c0 + 1), LAT);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_edges", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hall_decoder.md
# hall_decoder

Decodes the three motor Hall sensor inputs into an electrical sector, rotation direction, commutation period and fault flags. It sits beside the commutation controller on the same `HS` lines, and its outputs feed speed control, UART telemetry and fault shutdown logic. Inputs are synchronised and optionally glitch-filtered. A 120° Hall pattern is assumed.

## Interface
- `PERIOD_W`, default 20: width of the period counter and output.
- `STALL_CYCLES`, default 1000000: cycles without an accepted edge before `stalled` asserts. Must be < 2^PERIOD_W.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required by the glitch filter. Range 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `HS`  in  3  raw Hall sensor signals, asynchronous to `clk`.
- `fault_clr`  in  1  single-cycle pulse that clears sticky fault bits.
- `sector`  out  3  current sector, 0..5.
- `sector_valid`  out  1  `sector` reflects a legal Hall code.
- `dir`  out  1  1 = clockwise (sector increments), 0 = counter-clockwise.
- `edge_pulse`  out  1  one-cycle strobe on each accepted sector change.
- `period`  out  PERIOD_W  clk cycles between the last two accepted edges.
- `period_valid`  out  1  `period` is meaningful.
- `stalled`  out  1  no edge for `STALL_CYCLES` cycles.
- `fault`  out  2  sticky flags: bit0 = invalid code (000/111), bit1 = illegal jump.

## Operation
- Code mapping, using `{HS[2],HS[1],HS[0]}`:
  - 001→0, 011→1, 010→2, 110→3, 100→4, 101→5.
  - 000 and 111 are invalid.
- Input path: 2-flop synchroniser, then the optional filter, then the decode register. This gives the filtered code `hf`.
- When `hf` differs from the previously decoded code:
  - **Invalid code:** `sector_valid` := 0, set `fault[0]`, `sector` holds, no `edge_pulse`. The counter keeps running.
  - **Legal code after an invalid or reset state:** `sector` := new, `sector_valid` := 1. No `edge_pulse`, `dir` unchanged, period untouched.
  - **New = old+1 mod 6:** `dir` := 1, `edge_pulse`.
  - **New = old−1 mod 6:** `dir` := 0, `edge_pulse`.
  - **Any other jump:** set `fault[1]`, `sector` := new, no `edge_pulse`. Period state resets: `period_valid` := 0 and the counter is cleared.
- Period counter `cnt` increments every cycle and saturates at 2^PERIOD_W−1.
- On `edge_pulse`:
  - `period` := `cnt`+1, saturating.
  - `cnt` := 0.
  - `period_valid` := 1 only if the previous accepted edge exists and had the same `dir`, with no stall between the two edges. Otherwise `period_valid` := 0.
- A direction reversal therefore invalidates the period until one further edge in the new direction.
- Stall behaviour:
  - `stalled` := 1 and `period_valid` := 0 in the cycle where `cnt` reaches `STALL_CYCLES`.
  - `stalled` clears on the next `edge_pulse`. That edge yields `period_valid` = 0.
- Fault bits:
  - Sticky.
  - `fault_clr` clears them.
  - If `fault_clr` and a new fault occur in the same cycle, the new fault is set.

## Timing
- Reset values: `sector` 0, `sector_valid` 0, `dir` 0, `edge_pulse` 0, `period` 0, `period_valid` 0, `stalled` 0, `fault` 0, `cnt` 0. Synchroniser and filter state are also cleared to 000.
- Latency without the filter: a change of `HS` sampled at edge k is seen on the decoded outputs and `edge_pulse` after edge k+2.
- With the filter, add `DEBOUNCE_CYCLES` cycles.
- `edge_pulse` is exactly one cycle wide. `period`, `dir` and `period_valid` update in that same cycle.
- Reset asserted mid-rotation returns everything to the reset values immediately. The first legal code after release only sets `sector_valid`.
- A stall expiring in the same cycle as an edge: the edge wins. `stalled` stays 0, `period` is latched.

## Configuration
- `HALL_DEBOUNCE_EN` defined: a per-vector glitch filter is compiled in.
  - `hf` updates only after the synchronised code has been identical for `DEBOUNCE_CYCLES` consecutive cycles.
  - Shorter pulses are discarded entirely and raise no fault.
- `HALL_DEBOUNCE_EN` not defined: the filter is absent, `hf` is the synchroniser output, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `hall_pkg` holds:
  - the sector mapping function and the invalid-code constants 3'b000 and 3'b111;
  - the fault bit indices `FLT_INVALID` = 0 and `FLT_JUMP` = 1;
  - the direction constants `DIR_CW` = 1 and `DIR_CCW` = 0.
- Sub-module `hall_debounce` (3-bit vector filter with a stability counter) is instantiated only under `HALL_DEBOUNCE_EN`.

## Test plan
- **Forward rotation:** codes 001, 011, 010, 110, 100, 101, each held 100 cycles, filter off → one `edge_pulse` per change, `dir` = 1, `period` = 100 and `period_valid` = 1 from the second edge onward.
- **Reverse rotation:** same codes in reverse order → `dir` = 0, `period` = 100. After a forward-to-reverse switch, the first reverse edge has `period_valid` = 0.
- **Invalid code:** drive 111 for 50 cycles, then 011 → `fault` = 01 and `sector_valid` = 0 during 111. On 011, `sector` = 1 and `sector_valid` = 1 with no `edge_pulse`. `fault_clr` then returns `fault` to 00.
- **Illegal jump:** 001 → 110 → `fault[1]` set, `sector` = 3, no `edge_pulse`, `period_valid` = 0.
- **Stall:** `STALL_CYCLES` = 500 with `HS` held → `stalled` = 1 exactly 500 cycles after the last edge, `period_valid` = 0. The next edge clears `stalled` with `period_valid` = 0.
- **Glitch, filter on (`HALL_DEBOUNCE_EN`, `DEBOUNCE_CYCLES` = 16):** a 10-cycle glitch is ignored, with no `edge_pulse` and no fault. A 16-cycle hold is accepted with an `edge_pulse` 18 cycles after the `HS` change.
